uart_tx_fifo_drain: RTL and testbench
=====================================

// Module: uart_tx_fifo_drain
// PURPOSE
//  Serial transmitter that sits directly downstream of fifo_ram. It pops words
//  from the FIFO read side and shifts each one out as an 8N1-style UART frame.
//  It has its own baud/oversample tick generator and a START/DATA/STOP state machine.
//  Each pop is a single-cycle rd pulse. A word is popped only when the previous
//  frame has fully completed.
// PARAMETERS
//  DATA_WIDTH  8   data bits per frame; also the FIFO word width
//  SB_TICK     16  oversample ticks in the stop bit (16=1, 24=1.5, 32=2 stop bits)
//  DVSR_WIDTH  11  width of the dvsr port
// PORTS
//  clk          in   1           system clock; all logic on rising edge
//  reset        in   1           synchronous, active-high reset
//  dvsr         in   DVSR_WIDTH  oversample divisor; one tick every dvsr+1 clocks
//  fifo_empty   in   1           FIFO empty flag
//  fifo_r_data  in   DATA_WIDTH  FIFO head word; valid whenever fifo_empty=0
//  fifo_rd      out  1           pop strobe to FIFO rd, one-cycle pulse
//  tx           out  1           serial line, registered, idles high
//  tx_busy      out  1           1 whenever state != IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, tx=1, tx_busy=0, fifo_rd=0, tick counter=0,
//   s/n counters=0. fifo_rd is forced to 0 during reset, even when fifo_empty=0.
//  Tick generator: counter is held at 0 while in IDLE and counts from 0 on the first
//   START cycle. tick=1 when counter==dvsr, then the counter wraps to 0.
//   dvsr=0 means a tick every clock.
//  Result: each data bit lasts exactly 16*(dvsr+1) clocks. The stop bit lasts
//   SB_TICK*(dvsr+1) clocks.
//  IDLE:  tx=1. If fifo_empty=0 then: fifo_rd=1 this cycle (combinational),
//   b_reg<=fifo_r_data, s<=0, ->START. Otherwise stay in IDLE.
//   The word is latched in the same cycle as the pop.
//  START: tx=0. On tick: if s==15 then s<=0, n<=0, ->DATA; else s++.
//  DATA:  tx=b_reg[0] (LSB first). On tick with s==15: s<=0, b_reg>>=1, and
//   ->STOP if n==DATA_WIDTH-1, else n++. On tick with s<15: s++.
//  STOP:  tx=1. On tick: if s==SB_TICK-1 then ->IDLE; else s++.
//  tx is a register loaded from the next-state value. It falls in the cycle after
//   the pop and rises with the first stop-bit cycle.
//  Frame timing: a pop in cycle C gives tx=0 in C+1..C+16(dvsr+1).
//   Total frame = (16*(1+DATA_WIDTH)+SB_TICK)*(dvsr+1) clocks.
//   The earliest next pop is the cycle after the frame ends, so frames are
//   separated by exactly 1 idle clock (tx=1).
//  fifo_rd is never asserted when fifo_empty=1, and never outside IDLE.
//   At most one pop per frame.
//  fifo_r_data is ignored outside the IDLE pop cycle. FIFO data changing mid-frame
//   has no effect.
//  dvsr may only be changed while tx_busy=0. A mid-frame change alters bit timing
//   but the FSM must still complete the frame and return to IDLE.
//  Reset mid-frame: the next cycle has state=IDLE and tx=1. The partial frame is
//   abandoned; the popped word is lost and not re-popped.
// TESTING (DATA_WIDTH=8, SB_TICK=16, dvsr=3 -> 64 clocks/bit, 640-clock frame)
//  1 Reset with fifo_empty=0 -> fifo_rd=0, tx=1, tx_busy=0 on every reset cycle.
//  2 Head 0xA5, fifo_empty=0 falling in cycle C -> fifo_rd=1 in C only.
//    tx in 64-clock bits = 0,1,0,1,0,0,1,0,1,1 from C+1; tx_busy=1 for C+1..C+640.
//  3 FIFO holds 0x00 then 0xFF -> pops at C and C+641; frame bits 0,0x8,1 then
//    0,1x8,1; exactly one tx=1 idle clock between frames.
//  4 fifo_empty=1 for 2000 clocks -> fifo_rd never 1, tx stays 1, tx_busy stays 0.
//  5 Reset asserted for 1 clock at C+300 (inside a data bit) -> tx=1 and
//    tx_busy=0 at C+301; after release, the next head is popped and a full
//    640-clock frame is sent.
//  6 dvsr=0, head 0x3C -> 16-clock bits 0,0,0,1,1,1,1,0,0,1; frame=160 clocks.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// UART 8N1-style transmitter that pops words from a FIFO read port and shifts each
// one out LSB first, with a local oversample tick generator (16 ticks per bit).
module uart_tx_fifo_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int unsigned S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned N_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [DVSR_WIDTH-1:0] cnt_q, cnt_d;
  logic [S_W-1:0]        s_q, s_d;
  logic [N_W-1:0]        n_q, n_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  tick;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, tick generation and pop strobe
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    fifo_rd = 1'b0;
    // >= keeps the divider from running away if dvsr is lowered mid-frame
    tick    = (cnt_q >= dvsr);

    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DVSR_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty && !reset) begin
          fifo_rd = 1'b1;
          b_d     = fifo_r_data;
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_W'(15)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_W'(15)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_W'(DATA_WIDTH - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            state_d = IDLE;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so tx changes on the bit boundary
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: frame table plus reset, idle and
// mid-frame-reset sequences, all sampled one step after the falling edge.
module tb_uart_tx_fifo_drain;

  logic        clk;
  logic        reset;
  logic [10:0] dvsr;
  logic        fifo_empty;
  logic [7:0]  fifo_r_data;
  logic        fifo_rd;
  logic        tx;
  logic        tx_busy;

  int total = 0;
  int bad   = 0;

  uart_tx_fifo_drain dut (
    .clk        (clk),
    .reset      (reset),
    .dvsr       (dvsr),
    .fifo_empty (fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .tx_busy    (tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Frame record: word popped, divisor, expected line bits (index 0 sent first),
  // clocks per bit, and the FIFO state presented once the frame has started.
  typedef struct {
    logic [7:0]  data;
    logic [10:0] dv;
    logic [9:0]  frame;
    int          bit_clks;
    logic        nxt_empty;
    logic [7:0]  nxt_data;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Called inside an idle cycle before its rising edge; pops in this cycle and
  // returns sampled in the single idle cycle that follows the frame.
  task automatic send_frame(input vec_t v, input string tag);
    logic [2:0] first_bad;
    int         nbad;
    fifo_r_data = v.data;
    fifo_empty  = 1'b0;
    dvsr        = v.dv;
    #1;
    chk({tag, " pop"}, {29'd0, fifo_rd, tx, tx_busy}, {29'd0, 1'b1, 1'b1, 1'b0});
    for (int b = 0; b < 10; b++) begin
      nbad      = 0;
      first_bad = 3'b000;
      for (int k = 0; k < v.bit_clks; k++) begin
        @(negedge clk);
        if (b == 0 && k == 0) begin
          fifo_empty  = v.nxt_empty;
          fifo_r_data = v.nxt_data;
        end
        #1;
        if ({tx, tx_busy, fifo_rd} !== {v.frame[b], 1'b1, 1'b0}) begin
          if (nbad == 0) first_bad = {tx, tx_busy, fifo_rd};
          nbad++;
        end
      end
      if (nbad == 0) first_bad = {v.frame[b], 1'b1, 1'b0};
      chk($sformatf("%s bit%0d {tx,busy,rd}", tag, b), {29'd0, first_bad},
          {29'd0, v.frame[b], 1'b1, 1'b0});
    end
    @(negedge clk);
    #1;
    chk({tag, " gap {tx,busy,rd}"}, {29'd0, tx, tx_busy, fifo_rd},
        {29'd0, 1'b1, 1'b0, ~v.nxt_empty});
  endtask

  initial begin
    int rd_hi, tx_lo, busy_hi;

    vecs[0] = '{data: 8'hA5, dv: 11'd3, frame: 10'b1_1010_0101_0, bit_clks: 64,
                nxt_empty: 1'b1, nxt_data: 8'h5A};
    vecs[1] = '{data: 8'h00, dv: 11'd3, frame: 10'b1_0000_0000_0, bit_clks: 64,
                nxt_empty: 1'b0, nxt_data: 8'hFF};
    vecs[2] = '{data: 8'hFF, dv: 11'd3, frame: 10'b1_1111_1111_0, bit_clks: 64,
                nxt_empty: 1'b1, nxt_data: 8'h11};
    vecs[3] = '{data: 8'h3C, dv: 11'd0, frame: 10'b1_0011_1100_0, bit_clks: 16,
                nxt_empty: 1'b1, nxt_data: 8'hC3};

    reset       = 1'b1;
    fifo_empty  = 1'b0;
    fifo_r_data = 8'h77;
    dvsr        = 11'd3;

    // Reset held with a non-empty FIFO: no pop, line idle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("reset%0d {rd,tx,busy}", i), {29'd0, fifo_rd, tx, tx_busy},
          {29'd0, 1'b0, 1'b1, 1'b0});
    end
    @(negedge clk);
    reset      = 1'b0;
    fifo_empty = 1'b1;

    // Empty FIFO for 2000 clocks
    rd_hi = 0; tx_lo = 0; busy_hi = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (fifo_rd !== 1'b0) rd_hi++;
      if (tx !== 1'b1) tx_lo++;
      if (tx_busy !== 1'b0) busy_hi++;
    end
    chk("empty rd clocks", 32'(rd_hi), 32'd0);
    chk("empty tx low clocks", 32'(tx_lo), 32'd0);
    chk("empty busy clocks", 32'(busy_hi), 32'd0);

    // Table of frames; entries 1 and 2 run back to back
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // One-cycle reset in the middle of a data bit
    dvsr        = 11'd3;
    fifo_r_data = 8'h96;
    fifo_empty  = 1'b0;
    #1;
    chk("rst pop", {31'd0, fifo_rd}, 32'd1);
    @(negedge clk);
    fifo_r_data = 8'h5A;
    #1;
    chk("rst frame start {tx,busy,rd}", {29'd0, tx, tx_busy, fifo_rd},
        {29'd0, 1'b0, 1'b1, 1'b0});
    repeat (299) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst asserted {busy,rd}", {30'd0, tx_busy, fifo_rd}, {30'd0, 1'b1, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst after {tx,busy}", {30'd0, tx, tx_busy}, {30'd0, 1'b1, 1'b0});
    send_frame('{data: 8'h5A, dv: 11'd3, frame: 10'b1_0101_1010_0, bit_clks: 64,
                 nxt_empty: 1'b1, nxt_data: 8'h00}, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
